// File: rtl/axis_pkg.sv
// Shared stream-side constants: checker state encoding and the 8-bit LFSR
// polynomial used by both the checker's ready generator and random sources.
package axis_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_e;

    // x^8 + x^6 + x^5 + x^4 + 1, shift-left Fibonacci: feedback taps on bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr8_step(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/axis_checker_if.sv
// Single-beat AXI-stream style handshake bundle (data, valid, ready).
interface axis_checker_if #(
    parameter int WIDTH = 8
) ();

    logic [WIDTH-1:0] idata;
    logic             ivalid;
    logic             iready;

    modport master (
        output idata,
        output ivalid,
        input  iready
    );

    modport slave (
        input  idata,
        input  ivalid,
        output iready
    );

endinterface

// File: rtl/lfsr8.sv
// Free-running 8-bit maximal-length LFSR, shared between stream sources and sinks.
module lfsr8
    import axis_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    output logic [7:0] state
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= SEED;
        end else begin
            state <= lfsr8_step(state);
        end
    end

endmodule

// File: rtl/axis_checker.sv
// Stream sink that verifies an incrementing word sequence, counts accepted beats
// and mismatches, and drives constant or pseudo-random backpressure.
module axis_checker
    import axis_pkg::*;
#(
    parameter int         WIDTH  = 8,
    parameter int         ERRW   = 8,
    parameter int         CNTW   = 16,
    parameter bit         RANDOM = 1'b1,
    parameter logic [7:0] SEED   = 8'hA5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            clear,
    input  logic            enable,
    axis_checker_if.slave   s,
    output logic            locked,
    output logic            error,
    output logic [ERRW-1:0] errors,
    output logic [CNTW-1:0] beats
);

    state_e           state;
    logic [WIDTH-1:0] expected;
    logic [7:0]       lfsr;
    logic             ready_next;
    logic             xfer;

    function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] cnt);
        return (&cnt) ? cnt : cnt + ERRW'(1);
    endfunction

    lfsr8 #(
        .SEED (SEED)
    ) u_lfsr (
        .clock (clock),
        .reset (reset),
        .state (lfsr)
    );

    wire unused_lfsr = ^lfsr;

    // Ready is a pure function of enable and the LFSR, never of ivalid.
    always_comb begin
        ready_next = enable && (RANDOM ? (lfsr[0] | lfsr[1]) : 1'b1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s.iready <= 1'b0;
        end else begin
            s.iready <= ready_next;
        end
    end

    assign xfer   = s.ivalid && s.iready;
    assign locked = (state == LOCK);

    // Clear wins over a coincident transfer; that beat is dropped entirely.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= HUNT;
            expected <= '0;
            error    <= 1'b0;
            errors   <= '0;
            beats    <= '0;
        end else if (clear) begin
            state  <= HUNT;
            error  <= 1'b0;
            errors <= '0;
            beats  <= '0;
        end else if (xfer) begin
            beats <= beats + CNTW'(1);
            case (state)
                HUNT: begin
                    expected <= s.idata + WIDTH'(1);
                    state    <= LOCK;
                end
                LOCK: begin
                    if (s.idata == expected) begin
                        expected <= expected + WIDTH'(1);
                    end else begin
                        // Resync on the received word so a single slip counts once.
                        errors   <= sat_inc(errors);
                        error    <= 1'b1;
                        expected <= s.idata + WIDTH'(1);
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

endmodule
